muldiv_seq: RTL and testbench

//  Iterative multiply/divide sequencer owning the HI/LO registers of the multi-cycle MIPS core.

---
 rtl/muldiv_seq.sv | 175 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer that owns the HI/LO registers.
// Runs one operand bit per cycle and services mthi/mtlo when idle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sa, sb;
  logic [WIDTH-1:0]   d;
  logic [WIDTH-1:0]   p_hi, p_lo;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               dz_r;

  logic               is_div, is_signed, accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               dz_now;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign accept    = start && (state == S_IDLE || state == S_DONE);

  assign busy = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);
  assign dz   = dz_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PREP;
      S_PREP:  state_nxt = S_CALC;
      S_CALC:  if (cnt == CW'(WIDTH)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_PREP : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Magnitudes of the captured operands; unsigned ops pass straight through.
  always_comb begin
    mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  end

  // One iteration: shift-add multiply or restoring divide on {p_hi,p_lo}.
  always_comb begin
    mul_sum   = p_lo[0] ? ({1'b0, p_hi} + {1'b0, d}) : {1'b0, p_hi};
    div_shift = {p_hi, p_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, d};
    step_hi   = mul_sum[WIDTH:1];
    step_lo   = {mul_sum[0], p_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {p_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {p_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction; a zero divisor overrides whatever the loop produced.
  always_comb begin
    prod     = {p_hi, p_lo};
    prod_fix = (sa ^ sb) ? -prod : prod;
    dz_now   = is_div && (b_q == '0);
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (dz_now) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_hi = sa ? -p_hi : p_hi;
        fix_lo = (sa ^ sb) ? -p_lo : p_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      d    <= '0;
      p_hi <= '0;
      p_lo <= '0;
      hi_r <= '0;
      lo_r <= '0;
      dz_r <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
      end
      case (state)
        S_PREP: begin
          sa   <= is_signed & a_q[WIDTH-1];
          sb   <= is_signed & b_q[WIDTH-1];
          d    <= is_div ? mag_b : mag_a;
          p_lo <= is_div ? mag_a : mag_b;
          p_hi <= '0;
          cnt  <= '0;
        end
        // The extra cycle at cnt==WIDTH lets the finished result settle before FIX.
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt != CW'(WIDTH)) begin
            p_hi <= step_hi;
            p_lo <= step_lo;
          end
        end
        S_FIX: begin
          hi_r <= fix_hi;
          lo_r <= fix_lo;
          dz_r <= dz_now;
        end
        default: ;
      endcase
      // mthi/mtlo only when idle and not simultaneously launching.
      if (!busy && !start) begin
        if (hi_we) hi_r <= wdata;
        if (lo_we) lo_r <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with hand-computed results.
module tb_muldiv_seq;
  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive start for one cycle, then scramble operands to show they were captured.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = ~x; b = 32'h0000_1234;
    cyc = 0;
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (dz !== 1'b0) $display("FAIL reset_dz: got %b expected 0", dz); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h expected 0", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h expected 0", lo); else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if (busy !== 1'b1) $display("FAIL multu_busy: got %b expected 1", busy); else passed++;
    wait_done();
    total++; if (cyc !== 35) $display("FAIL multu_latency: got %0d cycles expected 35", cyc); else passed++;
    total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h expected fffffffe", hi); else passed++;
    total++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h expected 00000001", lo); else passed++;
    total++; if (dz !== 1'b0) $display("FAIL multu_dz: got %b expected 0", dz); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL multu_busy_done: got %b expected 0", busy); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0) $display("FAIL multu_done_pulse: got %b expected 0", done); else passed++;
  endtask

  task automatic test_mult();
    launch(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done();
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); else passed++;
    total++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_neg_lo: got %h expected fffffff1", lo); else passed++;
    @(posedge clk); #1;
    launch(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done();
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_negb_hi: got %h expected ffffffff", hi); else passed++;
    total++; if (lo !== 32'hFFFF_FFF2) $display("FAIL mult_negb_lo: got %h expected fffffff2", lo); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    launch(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done();
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_q: got %h expected fffffffd", lo); else passed++;
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_r: got %h expected ffffffff", hi); else passed++;
    @(posedge clk); #1;
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    total++; if (lo !== 32'h8000_0000) $display("FAIL div_min_q: got %h expected 80000000", lo); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL div_min_r: got %h expected 00000000", hi); else passed++;
    @(posedge clk); #1;
    launch(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done();
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_negb_q: got %h expected fffffffd", lo); else passed++;
    total++; if (hi !== 32'h0000_0001) $display("FAIL div_negb_r: got %h expected 00000001", hi); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    launch(OP_DIVU, 32'h0000_0064, 32'h0);
    wait_done();
    total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu0_q: got %h expected ffffffff", lo); else passed++;
    total++; if (hi !== 32'h0000_0064) $display("FAIL divu0_r: got %h expected 00000064", hi); else passed++;
    total++; if (dz !== 1'b1) $display("FAIL divu0_dz: got %b expected 1", dz); else passed++;
    @(posedge clk); #1;
    launch(OP_DIV, 32'hFFFF_FFFB, 32'h0);
    wait_done();
    total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL div0_q: got %h expected ffffffff", lo); else passed++;
    total++; if (hi !== 32'hFFFF_FFFB) $display("FAIL div0_r: got %h expected fffffffb", hi); else passed++;
    total++; if (dz !== 1'b1) $display("FAIL div0_dz: got %b expected 1", dz); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_busy_controls();
    launch(OP_MULT, 32'h0000_0002, 32'h0000_0003);
    repeat (6) begin
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b1; op = OP_MULTU; a = 32'h7; b = 32'h7;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0; hi_we = 1'b1; wdata = 32'h0000_00AA;
    @(posedge clk); #1;
    cyc++;
    hi_we = 1'b0;
    total++; if (hi !== 32'hFFFF_FFFB) $display("FAIL busy_hi_we: got %h expected fffffffb", hi); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL busy_calc: got %b expected 1", busy); else passed++;
    wait_done();
    total++; if (cyc !== 35) $display("FAIL busy_latency: got %0d cycles expected 35", cyc); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL busy_res_hi: got %h expected 00000000", hi); else passed++;
    total++; if (lo !== 32'h6) $display("FAIL busy_res_lo: got %h expected 00000006", lo); else passed++;
    total++; if (dz !== 1'b0) $display("FAIL busy_res_dz: got %b expected 0", dz); else passed++;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL no_queue: got busy %b expected 0", busy); else passed++;
    hi_we = 1'b1; wdata = 32'h0000_00AA;
    @(posedge clk); #1;
    hi_we = 1'b0;
    total++; if (hi !== 32'h0000_00AA) $display("FAIL mthi_idle: got %h expected 000000aa", hi); else passed++;
    total++; if (lo !== 32'h6) $display("FAIL mthi_lo_kept: got %h expected 00000006", lo); else passed++;
    lo_we = 1'b1; wdata = 32'h0000_0055;
    @(posedge clk); #1;
    lo_we = 1'b0;
    total++; if (lo !== 32'h0000_0055) $display("FAIL mtlo_idle: got %h expected 00000055", lo); else passed++;
    total++; if (hi !== 32'h0000_00AA) $display("FAIL mtlo_hi_kept: got %h expected 000000aa", hi); else passed++;
    start = 1'b1; op = OP_MULTU; a = 32'h0; b = 32'h0; hi_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; a = 32'h9; b = 32'h9;
    cyc = 0;
    total++; if (hi !== 32'h0000_00AA) $display("FAIL start_wins: got %h expected 000000aa", hi); else passed++;
    wait_done();
    total++; if (hi !== 32'h0) $display("FAIL start_wins_hi: got %h expected 00000000", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL start_wins_lo: got %h expected 00000000", lo); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    launch(OP_MULTU, 32'h3, 32'h4);
    wait_done();
    total++; if (lo !== 32'hC) $display("FAIL b2b_first_lo: got %h expected 0000000c", lo); else passed++;
    launch(OP_DIVU, 32'h0000_0064, 32'h0000_0007);
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", busy); else passed++;
    wait_done();
    total++; if (cyc !== 35) $display("FAIL b2b_latency: got %0d cycles expected 35", cyc); else passed++;
    total++; if (lo !== 32'hE) $display("FAIL b2b_q: got %h expected 0000000e", lo); else passed++;
    total++; if (hi !== 32'h2) $display("FAIL b2b_r: got %h expected 00000002", hi); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    launch(OP_DIVU, 32'h0000_0064, 32'h0000_0007);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", done); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL rst_mid_hi: got %h expected 00000000", hi); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL rst_mid_lo: got %h expected 00000000", lo); else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
    launch(OP_MULT, 32'h2, 32'h3);
    wait_done();
    total++; if (cyc !== 35) $display("FAIL rst_fresh_latency: got %0d cycles expected 35", cyc); else passed++;
    total++; if (lo !== 32'h6) $display("FAIL rst_fresh_lo: got %h expected 00000006", lo); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL rst_fresh_hi: got %h expected 00000000", hi); else passed++;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_controls();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
